// File: rtl/map_display_to_index_pkg.sv
// Game-matrix geometry shared by the display<->index mappers.
package map_display_to_index_pkg;

  localparam int X_OFFSET  = 336;
  localparam int Y_OFFSET  = 27;
  localparam int CELL      = 16;
  localparam int COLS      = 32;
  localparam int ROWS      = 32;
  localparam int CELL_LOG2 = $clog2(CELL);

  localparam int POS_X_W = 11;
  localparam int POS_Y_W = 10;
  localparam int IDX_X_W = 7;
  localparam int IDX_Y_W = 6;

endpackage

// File: rtl/map_display_to_index_cell_axis_counter.sv
// One axis of the raster tracker: sub-cell offset and cell index counters.
// The sub/idx/active/err outputs are the post-update values for the current
// pixel so the parent can register them together with its other outputs.
module map_display_to_index_cell_axis_counter #(
  parameter int CELL = 16,
  parameter int N    = 32,
  parameter int IW   = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     step,
  input  logic                     brk,
  output logic [$clog2(CELL)-1:0]  sub,
  output logic [IW-1:0]            idx,
  output logic                     active,
  output logic                     err
);

  localparam int SW = $clog2(CELL);

  logic [SW-1:0] sub_q;
  logic [IW-1:0] idx_q;
  logic          active_q;

  // Next-state: load restarts the axis, step advances it, a break while
  // tracking drops out of the area and flags the discontinuity.
  always_comb begin
    sub    = sub_q;
    idx    = idx_q;
    active = active_q;
    err    = 1'b0;
    if (load) begin
      sub    = '0;
      idx    = '0;
      active = 1'b1;
    end else if (step && active_q) begin
      if (sub_q == SW'(CELL - 1)) begin
        sub = '0;
        if (idx_q == IW'(N - 1)) begin
          active = 1'b0;
        end else begin
          idx = idx_q + 1'b1;
        end
      end else begin
        sub = sub_q + 1'b1;
      end
    end else if (brk && active_q) begin
      active = 1'b0;
      err    = 1'b1;
    end
  end

  // Tracker state; idle after reset until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sub_q    <= sub;
      idx_q    <= idx;
      active_q <= active;
    end
  end

endmodule

// File: rtl/map_display_to_index.sv
// Maps the raster pixel stream onto game-matrix cell index and in-cell
// offset using incremental counters locked to raster order.
module map_display_to_index
  import map_display_to_index_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 disp_valid,
  input  logic [POS_X_W-1:0]   disp_pos_x,
  input  logic [POS_Y_W-1:0]   disp_pos_y,
  output logic                 out_valid,
  output logic                 in_area,
  output logic [IDX_X_W-1:0]   matrix_idx_x,
  output logic [IDX_Y_W-1:0]   matrix_idx_y,
  output logic [CELL_LOG2-1:0] cell_off_x,
  output logic [CELL_LOG2-1:0] cell_off_y,
  output logic                 sync_err
);

  logic [POS_X_W-1:0] last_x;
  logic [POS_Y_W-1:0] last_y;

  logic x_origin, x_seq, x_load, x_step, x_brk;
  logic y_en, y_origin, y_seq, y_same, y_load, y_step, y_brk;

  logic [CELL_LOG2-1:0] x_sub, y_sub;
  logic [IDX_X_W-1:0]   x_idx;
  logic [IDX_Y_W-1:0]   y_idx;
  logic                 x_active, y_active, x_err, y_err;
  logic                 hit;

  // Classify the current pixel against the previous one on each axis.
  // Comparisons are widened by one bit so last+1 cannot wrap to zero.
  always_comb begin
    x_origin = disp_valid && (disp_pos_x == POS_X_W'(X_OFFSET));
    x_seq    = ({1'b0, disp_pos_x} == ({1'b0, last_x} + 1'b1));
    x_load   = x_origin;
    x_step   = disp_valid && !x_origin && x_seq;
    x_brk    = disp_valid && !x_origin && !x_seq;

    // The row tracker only looks at the first game-area pixel of each line.
    y_en     = x_origin;
    y_origin = (disp_pos_y == POS_Y_W'(Y_OFFSET));
    y_seq    = ({1'b0, disp_pos_y} == ({1'b0, last_y} + 1'b1));
    y_same   = (disp_pos_y == last_y);
    y_load   = y_en && y_origin;
    y_step   = y_en && !y_origin && y_seq;
    y_brk    = y_en && !y_origin && !y_seq && !y_same;

    hit      = disp_valid && x_active && y_active;
  end

  map_display_to_index_cell_axis_counter #(
    .CELL (CELL),
    .N    (COLS),
    .IW   (IDX_X_W)
  ) u_x_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (x_load),
    .step   (x_step),
    .brk    (x_brk),
    .sub    (x_sub),
    .idx    (x_idx),
    .active (x_active),
    .err    (x_err)
  );

  map_display_to_index_cell_axis_counter #(
    .CELL (CELL),
    .N    (ROWS),
    .IW   (IDX_Y_W)
  ) u_y_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (y_load),
    .step   (y_step),
    .brk    (y_brk),
    .sub    (y_sub),
    .idx    (y_idx),
    .active (y_active),
    .err    (y_err)
  );

  // Remember the previous position seen by each axis tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_x <= '0;
      last_y <= '0;
    end else begin
      if (disp_valid) last_x <= disp_pos_x;
      if (y_en)       last_y <= disp_pos_y;
    end
  end

  // Register outputs; index/offset are forced to zero outside the area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      in_area      <= 1'b0;
      matrix_idx_x <= '0;
      matrix_idx_y <= '0;
      cell_off_x   <= '0;
      cell_off_y   <= '0;
      sync_err     <= 1'b0;
    end else begin
      out_valid    <= disp_valid;
      in_area      <= hit;
      matrix_idx_x <= hit ? x_idx : '0;
      matrix_idx_y <= hit ? y_idx : '0;
      cell_off_x   <= hit ? x_sub : '0;
      cell_off_y   <= hit ? y_sub : '0;
      sync_err     <= x_err || y_err;
    end
  end

endmodule
